// File: rtl/seg_dynamic_scan.sv
// -----------------------------------------------------------------------------
// seg_dynamic_scan
//   Turns a 20-bit unsigned value into six time-multiplexed 7-segment digit
//   codes. These codes feed the 74HC595 serialiser directly.
//
//   The value is converted to BCD by a sequential double-dabble engine. The
//   engine runs one pass continuously: IDLE -> SHIFT x20 -> LOAD. At the end
//   of each pass it copies the result into the display registers in one
//   clock, so the display always sees a coherent set of digits.
//
//   Display rules:
//     - Leading zeros are blanked. A lit decimal point keeps itself and every
//       digit to its right visible, so 5 with point[2] shows "0.05".
//     - A minus sign takes the first blank position above the number.
//     - Digits are scanned one at a time, each for CNT_MAX+1 clocks.
//
// Ports
//   sys_clk    in   1   system clock
//   sys_rst_n  in   1   asynchronous reset, active-low
//   data       in   20  unsigned value to display
//   point      in   6   decimal point enable per digit, bit0 = rightmost
//   sign       in   1   1 = show minus sign
//   seg_en     in   1   1 = display on, 0 = all digits dark
//   sel        out  6   one-hot digit select, active-high, bit0 = rightmost
//   seg        out  8   segment code, active-low, [7]=dp, [6:0]=g..a
// -----------------------------------------------------------------------------
module seg_dynamic_scan #(
   parameter logic [15:0] CNT_MAX = 16'd49_999
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [19:0] data,
   input  logic [5:0]  point,
   input  logic        sign,
   input  logic        seg_en,
   output logic [5:0]  sel,
   output logic [7:0]  seg
);

   typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

   // conversion engine
   state_t      state_q, state_d;
   logic [4:0]  step_q, step_d;
   logic [19:0] bin_q, bin_d;
   logic [23:0] bcd_q, bcd_d;
   logic        smp_sign_q, smp_sign_d;
   logic [5:0]  smp_point_q, smp_point_d;

   // display registers
   logic [23:0] disp_bcd_q, disp_bcd_d;
   logic        disp_sign_q, disp_sign_d;
   logic [5:0]  disp_point_q, disp_point_d;

   // scanner
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [5:0]  sel_q, sel_d;
   logic [7:0]  seg_q, seg_d;

   logic [19:0] mag;
   logic [23:0] bcd_adj;
   logic [5:0]  shown;
   logic [5:0]  minus;
   logic        above;
   logic [3:0]  nib;
   logic [7:0]  code;

   // Active-low segment pattern for one BCD digit. The decimal point is off.
   function automatic logic [7:0] digit_code(input logic [3:0] v);
      case (v)
         4'd0:    digit_code = 8'hC0;
         4'd1:    digit_code = 8'hF9;
         4'd2:    digit_code = 8'hA4;
         4'd3:    digit_code = 8'hB0;
         4'd4:    digit_code = 8'h99;
         4'd5:    digit_code = 8'h92;
         4'd6:    digit_code = 8'h82;
         4'd7:    digit_code = 8'hF8;
         4'd8:    digit_code = 8'h80;
         4'd9:    digit_code = 8'h90;
         default: digit_code = 8'hFF;
      endcase
   endfunction

   // ---------------------------------------------------------------------------
   // Conversion engine next state
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default first, so no path can leave it
      // unassigned and infer a latch.
      state_d      = state_q;
      step_d       = step_q;
      bin_d        = bin_q;
      bcd_d        = bcd_q;
      smp_sign_d   = smp_sign_q;
      smp_point_d  = smp_point_q;
      disp_bcd_d   = disp_bcd_q;
      disp_sign_d  = disp_sign_q;
      disp_point_d = disp_point_q;

      // Saturate the magnitude. With a sign, the top digit must stay free for
      // the '-', so the limit is five digits instead of six.
      if (sign) mag = (data > 20'd99_999)  ? 20'd99_999  : data;
      else      mag = (data > 20'd999_999) ? 20'd999_999 : data;

      // Double-dabble correction: add 3 to any nibble >= 5 before the shift.
      // NOTE: blocking '=' is correct inside always_comb. Each statement
      // builds on the previous one, which is exactly what this loop needs.
      bcd_adj = bcd_q;
      for (int n = 0; n < 6; n++) begin
         if (bcd_q[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
      end

      case (state_q)
         IDLE: begin
            bin_d       = mag;
            bcd_d       = '0;
            smp_sign_d  = sign;
            smp_point_d = point;
            step_d      = '0;
            state_d     = SHIFT;
         end
         SHIFT: begin
            // The top BCD bit is always 0 before the last shift, because the
            // result never exceeds 999999. Dropping it loses nothing.
            {bcd_d, bin_d} = {bcd_adj[22:0], bin_q, 1'b0};
            step_d         = step_q + 5'd1;
            if (step_q == 5'd19) state_d = LOAD;
         end
         LOAD: begin
            disp_bcd_d   = bcd_q;
            disp_sign_d  = smp_sign_q;
            disp_point_d = smp_point_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Digit code for the current scan index
   // ---------------------------------------------------------------------------
   always_comb begin
      // A digit is shown if it or any digit above it is non-zero, or if it
      // has a decimal point at or above it. Digit 0 is always shown.
      shown = '0;
      above = 1'b0;
      for (int k = 5; k >= 0; k--) begin
         above    = above | (disp_bcd_q[4*k +: 4] != 4'd0) | disp_point_q[k];
         shown[k] = above | (k == 0);
      end

      // Shown digits form a contiguous block from digit 0 upward. The minus
      // sign therefore goes on the one blank digit that sits directly on top
      // of that block.
      minus = '0;
      for (int k = 1; k < 6; k++) begin
         minus[k] = disp_sign_q & ~shown[k] & shown[k-1];
      end

      nib = disp_bcd_q[{idx_q, 2'b00} +: 4];
      if (shown[idx_q])      code = digit_code(nib);
      else if (minus[idx_q]) code = 8'hBF;
      else                   code = 8'hFF;
      if (disp_point_q[idx_q]) code[7] = 1'b0;
   end

   // ---------------------------------------------------------------------------
   // Scanner next state
   // ---------------------------------------------------------------------------
   always_comb begin
      cnt_d = (cnt_q == CNT_MAX) ? 16'd0 : cnt_q + 16'd1;
      idx_d = idx_q;
      sel_d = sel_q;
      seg_d = seg_q;
      // sel and seg load together at the end of each dwell, so they always
      // describe the same digit.
      if (cnt_q == CNT_MAX) begin
         idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
         sel_d = 6'b000001 << idx_q;
         seg_d = code;
      end
      // Blanking only affects the outputs. The counter, the index and the
      // conversion keep running while the display is dark.
      if (!seg_en) begin
         sel_d = '0;
         seg_d = 8'hFF;
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= IDLE;
         step_q       <= '0;
         bin_q        <= '0;
         bcd_q        <= '0;
         smp_sign_q   <= 1'b0;
         smp_point_q  <= '0;
         disp_bcd_q   <= '0;
         disp_sign_q  <= 1'b0;
         disp_point_q <= '0;
         cnt_q        <= '0;
         idx_q        <= '0;
         sel_q        <= '0;
         seg_q        <= 8'hFF;
      end else begin
         // NOTE: non-blocking '<=' for all state. Every flop samples its
         // value from before the edge, whatever order these lines are in.
         state_q      <= state_d;
         step_q       <= step_d;
         bin_q        <= bin_d;
         bcd_q        <= bcd_d;
         smp_sign_q   <= smp_sign_d;
         smp_point_q  <= smp_point_d;
         disp_bcd_q   <= disp_bcd_d;
         disp_sign_q  <= disp_sign_d;
         disp_point_q <= disp_point_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         sel_q        <= sel_d;
         seg_q        <= seg_d;
      end
   end

   assign sel = sel_q;
   assign seg = seg_q;

endmodule

// File: tb/tb_seg_dynamic_scan.sv
// -----------------------------------------------------------------------------
// Testbench for seg_dynamic_scan.
//   The DUT runs with a short dwell (CNT_MAX = 9), so a full scan takes only
//   60 clocks.
//   Expected digit codes come from two sources:
//     - a hand-written table of vectors;
//     - a reference model that works on decimal arithmetic (divide and
//       modulo by powers of ten) and uses no BCD engine.
// -----------------------------------------------------------------------------
module tb_seg_dynamic_scan;

   localparam logic [15:0] CNT_MAX = 16'd9;
   localparam int          DWELL   = 10;
   localparam int          SETTLE  = 60;   // > 44 clk worst-case display latency

   logic        sys_clk   = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic [19:0] data      = '0;
   logic [5:0]  point     = '0;
   logic        sign      = 1'b0;
   logic        seg_en    = 1'b1;
   logic [5:0]  sel;
   logic [7:0]  seg;

   int n_checks = 0;
   int n_errors = 0;

   seg_dynamic_scan #(.CNT_MAX(CNT_MAX)) dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .data     (data),
      .point    (point),
      .sign     (sign),
      .seg_en   (seg_en),
      .sel      (sel),
      .seg      (seg)
   );

   always #5 sys_clk = ~sys_clk;

   // exp packs {digit5, ..., digit0}, eight bits each
   typedef struct packed {
      logic [19:0] data;
      logic [5:0]  point;
      logic        sign;
      logic [47:0] exp;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: timed out waiting for the DUT", name);
   endtask

   // advance n rising edges, then sample 1 ns later
   task automatic step(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   function automatic int unsigned pow10(input int k);
      int unsigned p = 1;
      for (int i = 0; i < k; i++) p = p * 10;
      return p;
   endfunction

   function automatic int unsigned clamp(input int unsigned d, input bit s);
      int unsigned lim = s ? 99999 : 999999;
      return (d > lim) ? lim : d;
   endfunction

   function automatic bit is_shown(input int unsigned mag, input bit [5:0] p, input int k);
      return (k == 0) || ((mag / pow10(k)) != 0) || ((p >> k) != 0);
   endfunction

   function automatic logic [7:0] dec_code(input int unsigned d);
      case (d)
         0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
         4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
         8: return 8'h80;  9: return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic [7:0] model_seg(input int unsigned d, input bit s,
                                            input bit [5:0] p, input int k);
      int unsigned mag = clamp(d, s);
      logic [7:0]  c;
      if (is_shown(mag, p, k))                                  c = dec_code((mag / pow10(k)) % 10);
      else if (s && k > 0 && is_shown(mag, p, k - 1))           c = 8'hBF;
      else                                                      c = 8'hFF;
      if (p[k]) c[7] = 1'b0;
      return c;
   endfunction

   function automatic logic [47:0] model_all(input int unsigned d, input bit s, input bit [5:0] p);
      logic [47:0] e;
      for (int k = 0; k < 6; k++) e[8*k +: 8] = model_seg(d, s, p, k);
      return e;
   endfunction

   // ------------- wait for a freshly latched digit-0 select -------------
   task automatic wait_first(input string name, output bit ok);
      int t = 0;
      ok = 1'b0;
      while (sel == 6'b000001 && t < 200) begin step(1); t++; end
      while (sel != 6'b000001 && t < 200) begin step(1); t++; end
      if (sel == 6'b000001 && t < 200) ok = 1'b1;
      else timeout(name);
   endtask

   // check one full scan of six digits against the expected codes
   task automatic scan_check(input string name, input logic [47:0] exp);
      bit ok;
      wait_first(name, ok);
      if (!ok) return;
      for (int k = 0; k < 6; k++) begin
         check($sformatf("%s sel%0d", name, k), {26'd0, sel}, {26'd0, 6'b000001 << k});
         check($sformatf("%s seg%0d", name, k), {24'd0, seg}, {24'd0, exp[8*k +: 8]});
         if (k < 5) step(DWELL);
      end
   endtask

   // hold reset for a few clocks, then release mid-cycle
   // (called from a point 1 ns after a rising edge)
   task automatic release_and_check_first(input string name);
      step(1);
      sys_rst_n = 1'b1;
      step(int'(CNT_MAX));
      check({name, " sel before first dwell"}, {26'd0, sel}, 32'd0);
      step(1);
      check({name, " first sel"}, {26'd0, sel}, 32'd1);
      check({name, " first seg"}, {24'd0, seg}, 32'hC0);
   endtask

   initial begin
      vecs[0] = '{20'd123456, 6'b000000, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82}};
      vecs[1] = '{20'd42,     6'b000000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'h99, 8'hA4}};
      vecs[2] = '{20'd5,      6'b000100, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'h40, 8'hC0, 8'h92}};
      vecs[3] = '{20'd1000000,6'b000000, 1'b0, {8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90}};
      vecs[4] = '{20'd200000, 6'b000000, 1'b1, {8'hBF, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90}};
      vecs[5] = '{20'd7,      6'b000001, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'h78}};
      vecs[6] = '{20'd0,      6'b000000, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}};

      // ---------------- reset state and first-digit timing ----------------
      data = 20'd123456;
      step(3);
      check("reset sel", {26'd0, sel}, 32'd0);
      check("reset seg", {24'd0, seg}, 32'hFF);
      release_and_check_first("post-reset");

      // ---------------- table vectors ----------------
      for (int i = 0; i < 7; i++) begin
         data  = vecs[i].data;
         point = vecs[i].point;
         sign  = vecs[i].sign;
         step(SETTLE);
         scan_check($sformatf("vec%0d", i), vecs[i].exp);
      end

      // ---------------- update latency: 0 -> 777777 ----------------
      begin
         logic [5:0] prev;
         int t = 0;
         data = 20'd777777;
         step(44);
         prev = sel;
         while (sel == prev && t < 3 * DWELL) begin step(1); t++; end
         if (sel == prev) timeout("latency");
         else check("latency seg", {24'd0, seg}, 32'hF8);
      end

      // ---------------- seg_en blanking ----------------
      begin
         int t = 0;
         int k = 0;
         step(SETTLE);
         seg_en = 1'b0;
         step(1);
         check("seg_en=0 sel", {26'd0, sel}, 32'd0);
         check("seg_en=0 seg", {24'd0, seg}, 32'hFF);
         step(3 * DWELL);
         check("seg_en=0 held sel", {26'd0, sel}, 32'd0);
         seg_en = 1'b1;
         while (sel == 6'd0 && t < DWELL + 1) begin step(1); t++; end
         if (sel == 6'd0) timeout("re-enable");
         else begin
            while (k < 6 && sel != (6'b000001 << k)) k++;
            check("re-enable one-hot", {31'd0, (k < 6)}, 32'd1);
            if (k < 6) check("re-enable seg", {24'd0, seg}, {24'd0, model_seg(777777, 1'b0, 6'd0, k)});
         end
      end

      // ---------------- reset in the middle of SHIFT ----------------
      data  = 20'd123456;
      point = '0;
      sign  = 1'b0;
      sys_rst_n = 1'b0;
      step(1);
      sys_rst_n = 1'b1;
      step(100);                       // 100 mod 22 = 12 -> engine is in SHIFT
      check("pre-abort sel lit", {31'd0, (sel != 6'd0)}, 32'd1);
      #2;
      sys_rst_n = 1'b0;
      #1;
      check("abort sel", {26'd0, sel}, 32'd0);
      check("abort seg", {24'd0, seg}, 32'hFF);
      @(posedge sys_clk);
      #1;
      release_and_check_first("post-abort");

      // ---------------- randomized against the reference model ----------------
      for (int i = 0; i < 10; i++) begin
         data  = 20'($urandom_range(0, 20'hFFFFF) >> $urandom_range(0, 19));
         sign  = 1'($urandom_range(0, 1));
         point = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
         step(SETTLE);
         scan_check($sformatf("rand%0d d=%0d s=%0d p=%b", i, data, sign, point),
                    model_all(data, sign, point));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
